// File: rtl/jtag_ir_dr_chain_if.sv
// TAP-side control/data bundle for jtag_ir_dr_chain.
// The master drives the TAP controls and user read data; the slave is the IR/DR chain.
interface jtag_ir_dr_chain_if #(
  parameter int USER_W = 32
);
  logic              tap_resetn_i;
  logic              tdi;
  logic              capture_ir_i;
  logic              shift_ir_i;
  logic              update_ir_i;
  logic              capture_dr_i;
  logic              shift_dr_i;
  logic              update_dr_i;
  logic              tselect_i;
  logic              enable_i;
  logic [USER_W-1:0] rd_data_i;
  logic              tdo;
  logic [3:0]        ir_o;
  logic [USER_W-1:0] wr_data_o;
  logic              wr_valid_o;
  logic              rd_ack_o;

  modport master (
    output tap_resetn_i, tdi, capture_ir_i, shift_ir_i, update_ir_i,
           capture_dr_i, shift_dr_i, update_dr_i, tselect_i, enable_i, rd_data_i,
    input  tdo, ir_o, wr_data_o, wr_valid_o, rd_ack_o
  );

  modport slave (
    input  tap_resetn_i, tdi, capture_ir_i, shift_ir_i, update_ir_i,
           capture_dr_i, shift_dr_i, update_dr_i, tselect_i, enable_i, rd_data_i,
    output tdo, ir_o, wr_data_o, wr_valid_o, rd_ack_o
  );
endinterface

// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction register plus IDCODE / USER / BYPASS data registers, all in the TCK domain.
// tdo is combinational from the shift registers; every other output is registered.
module jtag_ir_dr_chain #(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          USER_W     = 32
) (
  input logic               clk,
  input logic               rst,
  jtag_ir_dr_chain_if.slave bus
);

  typedef enum logic [1:0] {
    DR_IDCODE,
    DR_USER,
    DR_BYPASS
  } dr_sel_e;

  localparam logic [3:0] IR_IDCODE  = 4'h1;
  localparam logic [3:0] IR_USER_WR = 4'h2;
  localparam logic [3:0] IR_USER_RD = 4'h3;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  logic [3:0]        irShift_q, irShift_d;
  logic [3:0]        ir_q, ir_d;
  logic [31:0]       idcode_q, idcode_d;
  logic [USER_W-1:0] user_q, user_d;
  logic              bypass_q, bypass_d;
  logic [USER_W-1:0] wrData_q, wrData_d;
  logic              wrValid_q, wrValid_d;
  logic              rdAck_q, rdAck_d;
  logic              updIrPrev_q, updIrPrev_d;
  logic              updDrPrev_q, updDrPrev_d;
  logic              updIrEdge, updDrEdge;
  logic              drLsb;
  dr_sel_e           drSel;

  always_comb begin
    unique case (ir_q)
      IR_IDCODE:              drSel = DR_IDCODE;
      IR_USER_WR, IR_USER_RD: drSel = DR_USER;
      default:                drSel = DR_BYPASS;
    endcase
  end

  // A TAP reset cycle swallows any update edge so the detectors restart from low.
  assign updIrEdge = bus.update_ir_i & ~updIrPrev_q & bus.tap_resetn_i;
  assign updDrEdge = bus.update_dr_i & ~updDrPrev_q & bus.tap_resetn_i;

  always_comb begin
    irShift_d = irShift_q;
    if (bus.capture_ir_i) begin
      irShift_d = IR_CAPTURE;
    end else if (bus.shift_ir_i) begin
      irShift_d = {bus.tdi, irShift_q[3:1]};
    end

    ir_d = ir_q;
    if (!bus.tap_resetn_i) begin
      ir_d = IR_IDCODE;
    end else if (updIrEdge) begin
      ir_d = irShift_q;
    end

    updIrPrev_d = bus.tap_resetn_i & bus.update_ir_i;
    updDrPrev_d = bus.tap_resetn_i & bus.update_dr_i;

    idcode_d = idcode_q;
    user_d   = user_q;
    bypass_d = bypass_q;
    if (bus.capture_dr_i) begin
      unique case (drSel)
        DR_IDCODE: idcode_d = IDCODE_VAL;
        DR_USER:   user_d   = (ir_q == IR_USER_WR) ? wrData_q : bus.rd_data_i;
        default:   bypass_d = 1'b0;
      endcase
    end else if (bus.shift_dr_i) begin
      unique case (drSel)
        DR_IDCODE: idcode_d = {bus.tdi, idcode_q[31:1]};
        DR_USER:   user_d   = {bus.tdi, user_q[USER_W-1:1]};
        default:   bypass_d = bus.tdi;
      endcase
    end

    rdAck_d   = bus.capture_dr_i & (ir_q == IR_USER_RD);
    wrValid_d = updDrEdge & (ir_q == IR_USER_WR);
    wrData_d  = wrValid_d ? user_q : wrData_q;
  end

  always_comb begin
    unique case (drSel)
      DR_IDCODE: drLsb = idcode_q[0];
      DR_USER:   drLsb = user_q[0];
      default:   drLsb = bypass_q;
    endcase
  end

  assign bus.tdo = bus.enable_i ? (bus.tselect_i ? irShift_q[0] : drLsb) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irShift_q   <= IR_CAPTURE;
      ir_q        <= IR_IDCODE;
      idcode_q    <= '0;
      user_q      <= '0;
      bypass_q    <= 1'b0;
      wrData_q    <= '0;
      wrValid_q   <= 1'b0;
      rdAck_q     <= 1'b0;
      updIrPrev_q <= 1'b0;
      updDrPrev_q <= 1'b0;
    end else begin
      irShift_q   <= irShift_d;
      ir_q        <= ir_d;
      idcode_q    <= idcode_d;
      user_q      <= user_d;
      bypass_q    <= bypass_d;
      wrData_q    <= wrData_d;
      wrValid_q   <= wrValid_d;
      rdAck_q     <= rdAck_d;
      updIrPrev_q <= updIrPrev_d;
      updDrPrev_q <= updDrPrev_d;
    end
  end

  assign bus.ir_o       = ir_q;
  assign bus.wr_data_o  = wrData_q;
  assign bus.wr_valid_o = wrValid_q;
  assign bus.rd_ack_o   = rdAck_q;

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Bench for jtag_ir_dr_chain: directed scans with literal expectations plus random TAP traffic
// compared every cycle against a bit-queue model of the instruction and data registers.
module tb_jtag_ir_dr_chain;

  localparam int          USER_W     = 32;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;

  localparam logic [5:0] CAP_IR = 6'b100000;
  localparam logic [5:0] SH_IR  = 6'b010000;
  localparam logic [5:0] UPD_IR = 6'b001000;
  localparam logic [5:0] CAP_DR = 6'b000100;
  localparam logic [5:0] SH_DR  = 6'b000010;
  localparam logic [5:0] UPD_DR = 6'b000001;
  localparam logic [5:0] IDLE   = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_ir_dr_chain_if #(.USER_W(USER_W)) busIf ();

  jtag_ir_dr_chain #(
    .IDCODE_VAL(IDCODE_VAL),
    .USER_W    (USER_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  int checks    = 0;
  int failures  = 0;
  int wrPulses  = 0;
  int rdPulses  = 0;

  // Model: each register is a queue of bits, index 0 being the bit nearest tdo.
  bit                irQ[$];
  bit                idQ[$];
  bit                usrQ[$];
  bit                bypQ[$];
  logic [3:0]        mIr;
  logic [USER_W-1:0] mWrData;
  logic              mWrValid;
  logic              mRdAck;
  bit                updIrSeen;
  bit                updDrSeen;
  bit                modelReady = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    logic [3:0]        instr;
    logic [3:0]        capVal;
    logic [USER_W-1:0] oldWr;
    logic [31:0]       idVal;
    bit                irFire;
    bit                drFire;
    capVal = 4'b0101;
    idVal  = IDCODE_VAL;
    if (rst) begin
      irQ.delete();
      for (int i = 0; i < 4; i++) irQ.push_back(capVal[i]);
      idQ.delete();
      for (int i = 0; i < 32; i++) idQ.push_back(1'b0);
      usrQ.delete();
      for (int i = 0; i < USER_W; i++) usrQ.push_back(1'b0);
      bypQ.delete();
      bypQ.push_back(1'b0);
      mIr        = 4'h1;
      mWrData    = '0;
      mWrValid   = 1'b0;
      mRdAck     = 1'b0;
      updIrSeen  = 1'b0;
      updDrSeen  = 1'b0;
      modelReady = 1'b1;
      return;
    end
    if (!modelReady) return;

    instr  = mIr;
    oldWr  = mWrData;
    irFire = busIf.update_ir_i && !updIrSeen && busIf.tap_resetn_i;
    drFire = busIf.update_dr_i && !updDrSeen && busIf.tap_resetn_i;

    mWrValid = drFire && (instr == 4'h2);
    if (mWrValid) for (int i = 0; i < USER_W; i++) mWrData[i] = usrQ[i];
    mRdAck = busIf.capture_dr_i && (instr == 4'h3);

    if (busIf.capture_dr_i) begin
      if (instr == 4'h1) begin
        idQ.delete();
        for (int i = 0; i < 32; i++) idQ.push_back(idVal[i]);
      end else if (instr == 4'h2 || instr == 4'h3) begin
        usrQ.delete();
        for (int i = 0; i < USER_W; i++) usrQ.push_back(instr == 4'h2 ? oldWr[i] : busIf.rd_data_i[i]);
      end else begin
        bypQ[0] = 1'b0;
      end
    end else if (busIf.shift_dr_i) begin
      if (instr == 4'h1) begin
        void'(idQ.pop_front());
        idQ.push_back(busIf.tdi);
      end else if (instr == 4'h2 || instr == 4'h3) begin
        void'(usrQ.pop_front());
        usrQ.push_back(busIf.tdi);
      end else begin
        void'(bypQ.pop_front());
        bypQ.push_back(busIf.tdi);
      end
    end

    if (!busIf.tap_resetn_i) mIr = 4'h1;
    else if (irFire) for (int i = 0; i < 4; i++) mIr[i] = irQ[i];

    if (busIf.capture_ir_i) begin
      irQ.delete();
      for (int i = 0; i < 4; i++) irQ.push_back(capVal[i]);
    end else if (busIf.shift_ir_i) begin
      void'(irQ.pop_front());
      irQ.push_back(busIf.tdi);
    end

    updIrSeen = busIf.tap_resetn_i && busIf.update_ir_i;
    updDrSeen = busIf.tap_resetn_i && busIf.update_dr_i;
  endtask

  function automatic logic modelTdo();
    logic drBit;
    if (mIr == 4'h1) drBit = idQ[0];
    else if (mIr == 4'h2 || mIr == 4'h3) drBit = usrQ[0];
    else drBit = bypQ[0];
    if (!busIf.enable_i) return 1'b0;
    return busIf.tselect_i ? irQ[0] : drBit;
  endfunction

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Single compare process: every settled cycle, all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (modelReady) begin
      checkOutput("tdo", 64'(busIf.tdo), 64'(modelTdo()));
      checkOutput("ir_o", 64'(busIf.ir_o), 64'(mIr));
      checkOutput("wr_data_o", 64'(busIf.wr_data_o), 64'(mWrData));
      checkOutput("wr_valid_o", 64'(busIf.wr_valid_o), 64'(mWrValid));
      checkOutput("rd_ack_o", 64'(busIf.rd_ack_o), 64'(mRdAck));
    end
  end

  initial forever begin
    @(negedge clk);
    if (busIf.wr_valid_o === 1'b1) wrPulses++;
    if (busIf.rd_ack_o === 1'b1) rdPulses++;
  end

  task automatic applyStimulus(input logic [5:0] ctl, input logic tdiV, output logic tdoSeen);
    {busIf.capture_ir_i, busIf.shift_ir_i, busIf.update_ir_i,
     busIf.capture_dr_i, busIf.shift_dr_i, busIf.update_dr_i} = ctl;
    busIf.tdi = tdiV;
    @(negedge clk);
    tdoSeen = busIf.tdo;
    @(posedge clk);
    #1;
  endtask

  task automatic irScan(input logic [3:0] val);
    logic t;
    applyStimulus(CAP_IR, 1'b0, t);
    for (int i = 0; i < 4; i++) applyStimulus(SH_IR, val[i], t);
    applyStimulus(UPD_IR, 1'b0, t);
    applyStimulus(IDLE, 1'b0, t);
  endtask

  task automatic drScan(input logic [63:0] val, input int n, input int updHold, output logic [63:0] seen);
    logic t;
    seen = '0;
    applyStimulus(CAP_DR, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      applyStimulus(SH_DR, val[i], t);
      seen[i] = t;
    end
    for (int h = 0; h < updHold; h++) applyStimulus(UPD_DR, 1'b0, t);
    applyStimulus(IDLE, 1'b0, t);
  endtask

  initial begin
    logic [63:0] seen;
    logic [5:0]  ctl;
    logic        t;
    int          base;
    logic [3:0]  codes [5];
    codes = '{4'h1, 4'h2, 4'h3, 4'h7, 4'hF};

    busIf.tap_resetn_i = 1'b1;
    busIf.tdi          = 1'b0;
    busIf.capture_ir_i = 1'b0;
    busIf.shift_ir_i   = 1'b0;
    busIf.update_ir_i  = 1'b0;
    busIf.capture_dr_i = 1'b0;
    busIf.shift_dr_i   = 1'b0;
    busIf.update_dr_i  = 1'b0;
    busIf.tselect_i    = 1'b0;
    busIf.enable_i     = 1'b1;
    busIf.rd_data_i    = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset ir_o", 64'(busIf.ir_o), 64'h1);
    checkOutput("reset wr_data_o", 64'(busIf.wr_data_o), 64'h0);
    checkOutput("reset wr_valid_o", 64'(busIf.wr_valid_o), 64'h0);
    checkOutput("reset rd_ack_o", 64'(busIf.rd_ack_o), 64'h0);
    checkOutput("reset dr tdo", 64'(busIf.tdo), 64'h0);
    busIf.tselect_i = 1'b1;
    #1;
    checkOutput("reset ir shift tdo", 64'(busIf.tdo), 64'h1);
    busIf.tselect_i = 1'b0;

    drScan(64'h0, 32, 0, seen);
    checkOutput("idcode stream", seen, 64'h1000_0001);

    irScan(4'h2);
    checkOutput("ir after USER_WR scan", 64'(busIf.ir_o), 64'h2);
    base = wrPulses;
    drScan(64'hDEAD_BEEF, 32, 3, seen);
    checkOutput("user_wr data", 64'(busIf.wr_data_o), 64'hDEAD_BEEF);
    checkOutput("user_wr pulse count", 64'(wrPulses - base), 64'h1);

    irScan(4'h3);
    busIf.rd_data_i = 32'h1234_5678;
    base = rdPulses;
    drScan(64'h0, 32, 0, seen);
    checkOutput("user_rd stream", seen, 64'h1234_5678);
    checkOutput("user_rd ack count", 64'(rdPulses - base), 64'h1);
    checkOutput("user_rd ir held", 64'(busIf.ir_o), 64'h3);

    irScan(4'h7);
    drScan(64'b1101, 4, 0, seen);
    checkOutput("bypass delay", seen, 64'b1010);

    irScan(4'h1);
    applyStimulus(CAP_DR, 1'b0, t);
    for (int i = 0; i < 8; i++) applyStimulus(SH_DR, 1'b0, t);
    applyStimulus(CAP_DR | SH_DR, 1'b0, t);
    applyStimulus(IDLE, 1'b0, t);
    checkOutput("capture beats shift", 64'(t), 64'h1);

    irScan(4'h2);
    drScan(64'hA5A5_1234, 32, 1, seen);
    checkOutput("wr before tap reset", 64'(busIf.wr_data_o), 64'hA5A5_1234);
    busIf.tap_resetn_i = 1'b0;
    applyStimulus(IDLE, 1'b0, t);
    busIf.tap_resetn_i = 1'b1;
    checkOutput("tap reset ir_o", 64'(busIf.ir_o), 64'h1);
    checkOutput("tap reset keeps wr_data_o", 64'(busIf.wr_data_o), 64'hA5A5_1234);

    irScan(4'h2);
    base = wrPulses;
    applyStimulus(CAP_DR, 1'b0, t);
    for (int i = 0; i < 10; i++) applyStimulus(SH_DR, 1'($urandom), t);
    rst = 1'b1;
    applyStimulus(SH_DR | UPD_DR, 1'b1, t);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(IDLE, 1'b0, t);
    checkOutput("mid-scan reset no wr pulse", 64'(wrPulses - base), 64'h0);
    checkOutput("mid-scan reset ir_o", 64'(busIf.ir_o), 64'h1);
    checkOutput("mid-scan reset wr_data_o", 64'(busIf.wr_data_o), 64'h0);
    checkOutput("mid-scan reset tdo", 64'(busIf.tdo), 64'h0);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        busIf.tap_resetn_i = 1'b1;
        irScan(codes[$urandom_range(0, 4)]);
      end else begin
        rst                = ($urandom_range(0, 99) == 0);
        busIf.tap_resetn_i = ($urandom_range(0, 39) != 0);
        busIf.tselect_i    = 1'($urandom);
        busIf.enable_i     = ($urandom_range(0, 7) != 0);
        busIf.rd_data_i    = USER_W'($urandom);
        ctl                = 6'($urandom) & 6'($urandom);
        applyStimulus(ctl, 1'($urandom), t);
      end
    end
    rst = 1'b0;
    busIf.tap_resetn_i = 1'b1;
    applyStimulus(IDLE, 1'b0, t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_ir_dr_chain.md
JTAG_IR_DR_CHAIN -- requirements
Module: jtag_ir_dr_chain

Parameters
REQ-001 IDCODE_VAL, 32'h1000_0001, 32-bit value loaded into the IDCODE DR on capture; bit 0 SHALL be 1.
REQ-002 USER_W, 32, width of the USER_WR and USER_RD data registers; legal range 8-64.

Interface
REQ-003 clk  in  1  JTAG clock (TCK domain); every register in this block SHALL update on its rising edge only.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 tap_resetn_i  in  1  TAP reset from the TAP controller; low = Test-Logic-Reset.
REQ-006 tdi  in  1  serial data in.
REQ-007 capture_ir_i, shift_ir_i, update_ir_i  in  1 each  IR phase controls from the TAP controller.
REQ-008 capture_dr_i, shift_dr_i, update_dr_i  in  1 each  DR phase controls from the TAP controller.
REQ-009 tselect_i  in  1  selects the tdo source: 1 = IR, 0 = DR.
REQ-010 enable_i  in  1  tdo output enable.
REQ-011 rd_data_i  in  USER_W  value captured by USER_RD.
REQ-012 tdo  out  1  serial data out.
REQ-013 ir_o  out  4  active instruction.
REQ-014 wr_data_o  out  USER_W  last USER_WR update value.
REQ-015 wr_valid_o  out  1  one-cycle strobe when wr_data_o is updated.
REQ-016 rd_ack_o  out  1  one-cycle strobe when rd_data_i is captured.

Function
REQ-017 Instructions (4-bit) SHALL decode as follows: 4'h1 = IDCODE; 4'h2 = USER_WR; 4'h3 = USER_RD; 4'hF = BYPASS; every other code = BYPASS.
REQ-018 The IR shift register SHALL behave as follows:
- capture_ir_i loads 4'b0101.
- shift_ir_i shifts right: tdi enters bit 3, bit 0 drives tdo.
REQ-019 Selected DR per instruction: IDCODE = 32-bit register; USER_WR and USER_RD share one USER_W-bit register; BYPASS = 1-bit register.
REQ-020 The selected DR SHALL respond to capture_dr_i as follows:
- IDCODE loads IDCODE_VAL.
- BYPASS loads 0.
- USER_RD loads rd_data_i and pulses rd_ack_o in the next cycle.
- USER_WR loads the current wr_data_o.
REQ-021 shift_dr_i SHALL shift the selected DR right: tdi enters the MSB, the LSB drives tdo; unselected DRs SHALL hold.
REQ-022 If capture and shift of the same register are high in the same cycle, capture SHALL take priority.
REQ-023 update_ir_i/update_dr_i SHALL be edge-detected: the action fires only in the first cycle the signal is high after a cycle low, so a multi-cycle high level produces one action.
REQ-024 The update_ir edge SHALL copy the IR shift register into ir_o.
REQ-025 The update_dr edge with ir_o = USER_WR SHALL copy the DR into wr_data_o and assert wr_valid_o for exactly 1 cycle, in the same cycle wr_data_o changes.
- The update_dr edge SHALL have no effect for any other instruction.
REQ-026 tdo SHALL be combinational:
- tdo = enable_i ? (tselect_i ? IR bit 0 : selected DR LSB) : 0.
REQ-027 tap_resetn_i low SHALL, on the clock edge, load ir_o with 4'h1 (IDCODE) and clear the update edge detectors.
- It SHALL NOT clear wr_data_o.
REQ-028 ir_o SHALL be stable while a DR scan is in progress; a DR scan SHALL never alter ir_o.

Reset
REQ-029 With rst high at a clock edge, the next state SHALL be:
- ir_o = 4'h1, IR shift = 4'b0101.
- All DRs = 0, wr_data_o = 0.
- wr_valid_o = 0, rd_ack_o = 0.
- Edge detectors cleared.
REQ-030 rst SHALL override every other input in the same cycle, including a pending update edge.
REQ-031 rst asserted mid-scan SHALL abort the scan; no wr_valid_o or rd_ack_o pulse SHALL follow it.

Verification
REQ-032 Reset, then capture_dr, then 32 shift_dr cycles -> tdo streams IDCODE_VAL LSB first (1,0,0,0,... for 32'h1000_0001).
REQ-033 IR scan shifting 4'h2, update_ir -> ir_o = 4'h2; DR scan shifting 32'hDEAD_BEEF, update_dr held 3 cycles -> wr_data_o = 32'hDEAD_BEEF, wr_valid_o high for exactly 1 cycle.
REQ-034 IR = 4'h3, rd_data_i = 32'h1234_5678, capture_dr -> rd_ack_o pulses once; 32 shifts -> tdo emits 32'h1234_5678 LSB first.
REQ-035 IR = 4'h7 (undefined): DR scan with tdi = 1,0,1,1 -> tdo = 0,1,0,1 (1-bit bypass delay, captured 0 first).
REQ-036 Corner cases:
- capture_dr and shift_dr high together -> capture wins.
- tap_resetn_i low -> ir_o = 4'h1 and wr_data_o unchanged.
- rst during a USER_WR shift -> no wr_valid_o, all outputs at reset values.
